rule_unpack_avlstrm: RTL

//  Receive-side counterpart of the port-group rule stream. Accepts packed rule flits (RULE_W-bit

---
 rtl/rule_unpack_avlstrm.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rule_unpack_avlstrm.sv
// Unpacks DW-bit rule flits into a one-rule-per-beat stream, with sop/eop framing and stats.
// Optional RULE_DEDUP_EN: drop a rule equal to the previous rule emitted in the same packet.
module rule_unpack_avlstrm #(
  parameter int unsigned DW     = 512,
  parameter int unsigned RULE_W = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DW-1:0]     in_data,
  input  logic [5:0]        in_empty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [RULE_W-1:0] out_data,
  output logic [31:0]       stats_in_flit,
  output logic [31:0]       stats_out_rule,
  output logic [31:0]       stats_proto_err
);

  localparam int unsigned NSLOT = DW / RULE_W;
  localparam int unsigned IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     data_q;
  logic [NSLOT-1:0]  mask_q, in_mask, rest_mask;
  logic              eop_q, pkt_open_q, emitted_q;
  logic [31:0]       in_flit_q, out_rule_q, proto_err_q;
  logic [IW-1:0]     cur_idx;
  logic [RULE_W-1:0] cur_rule;
  logic              last_slot, skip, consume, flit_done;
  logic              in_fire, out_fire, new_pkt;

  // Padding is signalled by zero slots, so the empty count carries no information.
  logic unused_empty;
  assign unused_empty = ^in_empty;

  always_comb begin
    for (int i = 0; i < NSLOT; i++) in_mask[i] = |in_data[i*RULE_W +: RULE_W];
  end

  // Lowest set bit of the remaining mask is the current rule.
  always_comb begin
    cur_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (mask_q[i]) cur_idx = IW'(i);
    end
  end

  assign cur_rule  = data_q[32'(cur_idx) * RULE_W +: RULE_W];
  assign rest_mask = mask_q & ~(NSLOT'(1) << cur_idx);
  assign last_slot = (rest_mask == '0);
  assign new_pkt   = in_sop | ~pkt_open_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef RULE_DEDUP_EN
  logic [RULE_W-1:0] last_rule_q;

  // The final rule of an eop flit is kept even if repeated, since it carries eop.
  assign skip = (cur_rule == last_rule_q) && !(eop_q && last_slot);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_rule_q <= '0;
    end else if (in_fire && new_pkt) begin
      last_rule_q <= '0;
    end else if (out_fire && (out_data != '0)) begin
      last_rule_q <= out_data;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    consume   = 1'b0;
    flit_done = 1'b0;
    if (state_q == StScan) begin
      if (mask_q != '0) begin
        if (skip) begin
          consume = 1'b1;
        end else begin
          out_valid = 1'b1;
          out_data  = cur_rule;
          out_sop   = ~emitted_q;
          out_eop   = eop_q & last_slot;
          consume   = out_ready;
        end
        flit_done = consume & last_slot;
      end else if (eop_q) begin
        // Rule-less eop flit: terminator beat closes the packet.
        out_valid = 1'b1;
        out_eop   = 1'b1;
        out_sop   = ~emitted_q;
        flit_done = out_ready;
      end else begin
        flit_done = 1'b1;
      end
    end
    in_ready = Rst_n & ((state_q == StIdle) | flit_done);
    if (in_valid && in_ready) begin
      state_d = StScan;
    end else if (flit_done) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      mask_q      <= '0;
      eop_q       <= 1'b0;
      pkt_open_q  <= 1'b0;
      emitted_q   <= 1'b0;
      in_flit_q   <= '0;
      out_rule_q  <= '0;
      proto_err_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        data_q     <= in_data;
        mask_q     <= in_mask;
        eop_q      <= in_eop;
        pkt_open_q <= ~in_eop;
      end else if (consume) begin
        mask_q <= rest_mask;
      end
      if (in_fire && new_pkt) begin
        emitted_q <= 1'b0;
      end else if (out_fire) begin
        emitted_q <= 1'b1;
      end
      if (in_fire) in_flit_q <= in_flit_q + 32'd1;
      if (out_fire && (out_data != '0)) out_rule_q <= out_rule_q + 32'd1;
      if (in_fire && in_sop && pkt_open_q) proto_err_q <= proto_err_q + 32'd1;
    end
  end

  assign stats_in_flit   = in_flit_q;
  assign stats_out_rule  = out_rule_q;
  assign stats_proto_err = proto_err_q;

endmodule
